shifter_arbiter: RTL
====================

Name: shifter_arbiter

Overview:
Shares the single 32-bit barrel shifter between two requesters: port 0 (execute stage) and port 1 (multi-cycle multiply/divide sequencer). Arbitrates round-robin, launches one shift per cycle, and registers the result in a one-entry output buffer with valid/ready backpressure. Sits beside the ALU in the execute datapath; the shifter datapath is instantiated inside it.

Parameters:
WIDTH, 32, data width of operands and result
SHW, 5, shift-amount width (log2 WIDTH)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_data  in  WIDTH  port 0 operand
req0_shamt  in  SHW  port 0 shift amount
req0_dir  in  1  port 0 direction, 0 left, 1 right
req0_arith  in  1  port 0 right-shift type, 0 logic, 1 arithmetic
req1_valid, req1_ready, req1_data, req1_shamt, req1_dir, req1_arith  same as port 0, for port 1
resp_valid  out  1  result buffer holds a valid result
resp_ready  in  1  consumer takes result this cycle
resp_data  out  WIDTH  shifted result
resp_port  out  1  requester that owns resp_data (0 or 1)

Behaviour:
- Reset (rstn low, asynchronous): resp_valid=0, resp_data=0, resp_port=0, last_grant=1 (port 0 wins the first contention); req*_ready read 0 while rstn is low.
- can_accept = !resp_valid | resp_ready. Combinational, same cycle.
- Grant, combinational:
  - Only one port valid: that port.
  - Both valid: the port != last_grant.
  - Neither valid: no grant.
- reqN_ready = can_accept & grant==N. At most one ready per cycle. ready does not depend on resp_valid of the same port beyond can_accept.
- Handshake: transfer when reqN_valid & reqN_ready.
- On transfer, at the next clk edge:
  - resp_data <= shift(reqN_data, reqN_shamt, reqN_dir, reqN_arith).
  - resp_port <= N; resp_valid <= 1; last_grant <= N.
- Latency: exactly 1 cycle from accept to resp_valid. Throughput is 1 per cycle while resp_ready stays high.
- Shift semantics:
  - dir=0: logical left, arith ignored.
  - dir=1, arith=0: logical right.
  - dir=1, arith=1: arithmetic right, sign = data[WIDTH-1].
  - shamt=0 passes the operand unchanged.
- Buffer states:
  - EMPTY (resp_valid=0): on transfer -> FULL; else stay.
  - FULL, resp_ready=1 with a transfer: stay FULL and load the new result (simultaneous drain and fill, no bubble).
  - FULL, resp_ready=1 without a transfer: -> EMPTY; resp_data holds its old value.
  - FULL, resp_ready=0: stay; resp_data and resp_port stable; both req*_ready=0.
- last_grant updates only on an actual transfer, not on a grant stalled by backpressure.
- Requesters must hold their payload stable while valid and not ready. The arbiter samples the payload only on the transfer cycle.
- Reset asserted mid-operation: the buffered result is discarded and last_grant returns to 1. No pending request is remembered.

Decomposition:
- Shared package shift_pkg:
  - constants SHIFT_LEFT=0, SHIFT_RIGHT=1, SHIFT_LOGIC=0, SHIFT_ARITH=1
  - PORT_EXE=0, PORT_MD=1
  - typedef shift_req_t {data, shamt, dir, arith}
- One sub-module: the existing combinational Shifter (Input, index, direction, AorL, Result), instantiated once and fed from the granted port's mux.
- Arbiter, mux and output buffer stay in this module.

Test Plan:
- Reset: hold rstn=0 with both valids high -> resp_valid=0, req0_ready=req1_ready=0. Release rstn -> first grant goes to port 0.
- Single port 0: data=0x0000_00F0, shamt=4, dir=0 -> resp_data=0x0000_0F00, resp_port=0 one cycle after accept.
- Arithmetic vs logic right: data=0x8000_0010, shamt=4.
  - arith=1 -> 0xF800_0001.
  - arith=0 -> 0x0800_0001.
- Contention, resp_ready=1: both valid for 4 cycles -> grants alternate 0,1,0,1, and resp_port follows one cycle later.
- Backpressure: resp_valid=1 with resp_ready=0 for 3 cycles -> resp_data stable, both readys 0, last_grant unchanged. Raise resp_ready -> drain and next accept happen in the same cycle with no bubble.
- Mid-operation reset: pulse rstn low asynchronously (between edges) while FULL -> resp_valid drops immediately. After release, port 0 has priority again.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared constants and types for the shifter arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int SHIFT_WIDTH = 32;
    localparam int SHIFT_SHW   = 5;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;
    localparam logic SHIFT_LOGIC = 1'b0;
    localparam logic SHIFT_ARITH = 1'b1;

    localparam logic PORT_EXE = 1'b0;
    localparam logic PORT_MD  = 1'b1;

    typedef struct packed {
        logic [SHIFT_WIDTH-1:0] data;
        logic [SHIFT_SHW-1:0]   shamt;
        logic                   dir;
        logic                   arith;
    } shift_req_t;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

`default_nettype wire

// File: rtl/shifter_arbiter_if.sv
// ============================================================================
// Module   : shifter_arbiter_if
// Purpose  : Two request ports plus the buffered response of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shifter_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [SHW-1:0]   req0_shamt;
    logic             req0_dir;
    logic             req0_arith;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [SHW-1:0]   req1_shamt;
    logic             req1_dir;
    logic             req1_arith;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_port;

    // Requesters and the result consumer.
    modport master (
        output req0_valid, req0_data, req0_shamt, req0_dir, req0_arith,
        input  req0_ready,
        output req1_valid, req1_data, req1_shamt, req1_dir, req1_arith,
        input  req1_ready,
        input  resp_valid, resp_data, resp_port,
        output resp_ready
    );

    // The arbiter itself.
    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_dir, req0_arith,
        output req0_ready,
        input  req1_valid, req1_data, req1_shamt, req1_dir, req1_arith,
        output req1_ready,
        output resp_valid, resp_data, resp_port,
        input  resp_ready
    );

endinterface

`default_nettype wire

// File: rtl/shifter_arbiter_shifter.sv
// ============================================================================
// Module   : shifter_arbiter_shifter
// Purpose  : Combinational barrel shifter (left, logical right, arith right).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_arbiter_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int SHW   = SHIFT_SHW
) (
    input  logic [WIDTH-1:0] Input,
    input  logic [SHW-1:0]   index,
    input  logic             direction,
    input  logic             AorL,
    output logic [WIDTH-1:0] Result
);

    // Separate statements keep the arithmetic shift in a signed context.
    always_comb begin
        Result = Input << index;
        if (direction == SHIFT_RIGHT) begin
            if (AorL == SHIFT_ARITH) begin
                Result = $signed(Input) >>> index;
            end else begin
                Result = Input >> index;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/shifter_arbiter.sv
// ============================================================================
// Module   : shifter_arbiter
// Purpose  : Round-robin share of one barrel shifter between two requesters,
//            with a one-entry valid/ready result buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int SHW   = SHIFT_SHW
) (
    input  logic             clk,
    input  logic             rstn,
    shifter_arbiter_if.slave bus
);

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_port_q, resp_port_d;
    logic             last_grant_q, last_grant_d;

    logic             can_accept;
    logic             grant_valid;
    logic             grant_port;
    logic             transfer;
    shift_req_t       sel_req;
    logic [WIDTH-1:0] shift_result;

    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_port  = PORT_EXE;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_port = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_port = PORT_MD;
        end
    end

    // rstn gates ready so nothing is accepted while reset is held.
    assign can_accept     = (state_q == BUF_EMPTY) | bus.resp_ready;
    assign transfer       = rstn & can_accept & grant_valid;
    assign bus.req0_ready = transfer & (grant_port == PORT_EXE);
    assign bus.req1_ready = transfer & (grant_port == PORT_MD);

    always_comb begin
        if (grant_port == PORT_MD) begin
            sel_req = '{data: bus.req1_data, shamt: bus.req1_shamt,
                        dir: bus.req1_dir, arith: bus.req1_arith};
        end else begin
            sel_req = '{data: bus.req0_data, shamt: bus.req0_shamt,
                        dir: bus.req0_dir, arith: bus.req0_arith};
        end
    end

    shifter_arbiter_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .Input     (sel_req.data),
        .index     (sel_req.shamt),
        .direction (sel_req.dir),
        .AorL      (sel_req.arith),
        .Result    (shift_result)
    );

    always_comb begin
        state_d      = state_q;
        resp_data_d  = resp_data_q;
        resp_port_d  = resp_port_q;
        last_grant_d = last_grant_q;
        if (transfer) begin
            state_d      = BUF_FULL;
            resp_data_d  = shift_result;
            resp_port_d  = grant_port;
            last_grant_d = grant_port;
        end else if (state_q == BUF_FULL && bus.resp_ready) begin
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= BUF_EMPTY;
            resp_data_q  <= '0;
            resp_port_q  <= PORT_EXE;
            last_grant_q <= PORT_MD;
        end else begin
            state_q      <= state_d;
            resp_data_q  <= resp_data_d;
            resp_port_q  <= resp_port_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.resp_valid = (state_q == BUF_FULL);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_port  = resp_port_q;

endmodule

`default_nettype wire
